// File: rtl/qtree_stream_guard.sv
// rtl/qtree_stream_guard.sv - 2-entry skid slice that validates post-order QTree token streams.
// Optional stats counters are built when QTREE_GUARD_STATS_EN is defined.
module qtree_stream_guard #(
  parameter int DATA_W      = 67,
  parameter int N_TREES     = 2,
  parameter int TAG3_LEGAL  = 1,
  parameter int STACK_DEPTH = 256
) (
  input  logic              clk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              done,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [15:0]       tok_cnt,
  output logic [7:0]        tree_cnt
);

  logic              live;
  logic [1:0]        cnt;
  logic [DATA_W-1:0] tail_data;
  logic              tail_last;
  logic [8:0]        depth;
  logic [8:0]        base;
  logic [8:0]        depth_next;
  logic [8:0]        occ;
  logic [7:0]        tcnt;
  logic [2:0]        code;
  logic [1:0]        tag;
  logic              is_node;
  logic              illegal;
  logic              is_leaf;
  logic              push;
  logic              pop;

  // live holds s_tready low until the first edge after reset release
  assign s_tready = live && (cnt != 2'd2) && !done;
  assign m_tvalid = (cnt != 2'd0);
  assign push     = s_tvalid && s_tready;
  assign pop      = m_tvalid && m_tready;

  assign tag     = s_tdata[2:1];
  assign is_node = (tag == 2'd2);
  assign illegal = (tag == 2'd3) && (TAG3_LEGAL == 0);
  assign is_leaf = !is_node && !illegal;
  assign occ     = depth - base;

  always_comb begin
    code       = 3'd0;
    depth_next = depth;
    if (illegal) begin
      code = 3'd3;
    end else if (is_node && (occ < 9'd4)) begin
      code = 3'd1;
    end else if (is_leaf && (depth == 9'(STACK_DEPTH))) begin
      code = 3'd2;
    end else begin
      depth_next = is_node ? (depth - 9'd3) : (depth + 9'd1);
    end
    if ((code == 3'd0) && s_tlast && ((depth_next - base) != 9'd1)) begin
      code = 3'd4;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      live      <= 1'b0;
      cnt       <= 2'd0;
      m_tdata   <= '0;
      m_tlast   <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else begin
      live <= 1'b1;
      case (cnt)
        2'd0: if (push) begin
          m_tdata <= s_tdata;
          m_tlast <= s_tlast;
          cnt     <= 2'd1;
        end
        2'd1: if (push && pop) begin
          m_tdata <= s_tdata;
          m_tlast <= s_tlast;
        end else if (push) begin
          tail_data <= s_tdata;
          tail_last <= s_tlast;
          cnt       <= 2'd2;
        end else if (pop) begin
          cnt <= 2'd0;
        end
        default: if (pop) begin
          m_tdata <= tail_data;
          m_tlast <= tail_last;
          cnt     <= 2'd1;
        end
      endcase
    end
  end

  // Shape tracking; only the first error is latched
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      depth    <= 9'd0;
      base     <= 9'd0;
      tcnt     <= 8'd0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 3'd0;
    end else if (push) begin
      depth <= depth_next;
      if ((code != 3'd0) && !err) begin
        err      <= 1'b1;
        err_code <= code;
      end
      if (s_tlast) begin
        base <= depth_next;
        tcnt <= tcnt + 8'd1;
        if (tcnt == 8'(N_TREES - 1)) done <= 1'b1;
      end
    end
  end

`ifdef QTREE_GUARD_STATS_EN
  logic [15:0] tok_q;
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) tok_q <= 16'd0;
    else if (push && (tok_q != 16'hFFFF)) tok_q <= tok_q + 16'd1;
  end
  assign tok_cnt  = tok_q;
  assign tree_cnt = tcnt;
`else
  assign tok_cnt  = 16'd0;
  assign tree_cnt = 8'd0;
`endif

endmodule
